// File: rtl/mesh_router_wh_pkg.sv
// mesh_pkg: shared definitions for the wormhole mesh router.
//   - port index constants (N/E/S/W/L)
//   - head/tail flag bit positions as functions of the payload width
//   - per-input state enum
//   - deterministic XY route function
package mesh_pkg;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;
    localparam int unsigned NUM_PORTS = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } in_state_e;

    function automatic int unsigned head_bit(input int unsigned data_width);
        return data_width + 32'd1;
    endfunction

    function automatic int unsigned tail_bit(input int unsigned data_width);
        return data_width;
    endfunction

    // X is resolved completely before Y, which keeps the mesh deadlock free.
    function automatic logic [2:0] xy_route(input int unsigned cur_x, input int unsigned cur_y,
                                            input int unsigned dst_x, input int unsigned dst_y);
        logic [2:0] r;
        if (cur_x == dst_x && cur_y == dst_y) begin
            r = PORT_L;
        end else if (cur_x < dst_x) begin
            r = PORT_E;
        end else if (cur_x > dst_x) begin
            r = PORT_W;
        end else if (cur_y < dst_y) begin
            r = PORT_S;
        end else begin
            r = PORT_N;
        end
        return r;
    endfunction

endpackage

// File: rtl/mesh_router_wh_if.sv
// mesh_router_wh_if: five-lane flit bus of one router node.
//   in_flit/in_valid/in_ready   : upstream lanes into the router
//   out_flit/out_valid/out_ready: downstream lanes out of the router
//   err_drop/err_proto          : one-cycle error pulses
// master = traffic source/sink side, slave = router side.
interface mesh_router_wh_if #(
    parameter int unsigned FLIT_W = 34
);
    logic [5*FLIT_W-1:0] in_flit;
    logic [4:0]          in_valid;
    logic [4:0]          in_ready;
    logic [5*FLIT_W-1:0] out_flit;
    logic [4:0]          out_valid;
    logic [4:0]          out_ready;
    logic                err_drop;
    logic                err_proto;

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid, err_drop, err_proto
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid, err_drop, err_proto
    );
endinterface

// File: rtl/mesh_router_wh_noc_flit_fifo.sv
// noc_flit_fifo: synchronous FIFO with first-word-fall-through head.
//   i_wr_en/i_wr_data : push (ignored when full)
//   i_rd_en           : pop  (ignored when empty)
//   o_rd_data         : current head entry
//   o_full/o_empty    : occupancy flags
module noc_flit_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en && !o_full) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_rd_en && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (i_wr_en && !o_full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end
endmodule

// File: rtl/mesh_router_wh.sv
// mesh_router_wh: five-port wormhole mesh router with XY routing.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mesh_router_wh_if.slave (input lanes, output lanes, error pulses)
// Each input has a FIFO and a small state machine; each output holds a lock
// (valid + owner) for a whole packet and grants round-robin while unlocked.
module mesh_router_wh
    import mesh_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MESH_SIZE_X = 4,
    parameter int unsigned MESH_SIZE_Y = 4,
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0
) (
    input logic              clk,
    input logic              rst,
    mesh_router_wh_if.slave  bus
);
    localparam int unsigned FLIT_W = DATA_WIDTH + 32'd2;
    localparam int unsigned HEAD_B = head_bit(DATA_WIDTH);
    localparam int unsigned TAIL_B = tail_bit(DATA_WIDTH);
    // Bit p set when output p has a neighbour (L always present).
    localparam logic [4:0] PORT_PRESENT = {1'b1,
                                           (X_COORD != 32'd0),
                                           (Y_COORD != MESH_SIZE_Y - 32'd1),
                                           (X_COORD != MESH_SIZE_X - 32'd1),
                                           (Y_COORD != 32'd0)};

    logic [FLIT_W-1:0] w_head [5];
    logic [2:0]        w_rt [5];
    logic [4:0]        w_empty, w_full, w_push, w_pop, w_rt_ok;
    logic [4:0]        w_out_valid, w_out_fire, w_gnt_vld, w_gnt_to_in;
    logic [2:0]        w_gnt_idx [5];
    logic              w_drop_evt, w_proto_evt;
    int                w_cand;

    in_state_e         r_state [5];
    logic [2:0]        r_route [5];
    logic [4:0]        r_lock_vld;
    logic [2:0]        r_lock_own [5];
    logic [2:0]        r_rr [5];
    logic              r_err_drop, r_err_proto;

    assign bus.in_ready  = ~w_full & {5{~rst}};
    assign bus.err_drop  = r_err_drop;
    assign bus.err_proto = r_err_proto;

    for (genvar p = 0; p < 5; p++) begin : g_port
        assign w_push[p] = bus.in_valid[p] && !w_full[p] && !rst;

        noc_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_push[p]),
            .i_wr_data (bus.in_flit[p*FLIT_W +: FLIT_W]),
            .i_rd_en   (w_pop[p]),
            .o_rd_data (w_head[p]),
            .o_full    (w_full[p]),
            .o_empty   (w_empty[p])
        );

        // Route of whatever sits at the FIFO head; only meaningful for head flits.
        assign w_rt[p]    = xy_route(X_COORD, Y_COORD,
                                     32'(w_head[p][DATA_WIDTH-1 -: COORD_W]),
                                     32'(w_head[p][DATA_WIDTH-1-COORD_W -: COORD_W]));
        assign w_rt_ok[p] = PORT_PRESENT[w_rt[p]];

        // An output is driven only by its lock owner, and only while that owner forwards.
        assign w_out_valid[p] = !rst && r_lock_vld[p] && !w_empty[r_lock_own[p]]
                                && (r_state[r_lock_own[p]] == ST_FWD);
        assign w_out_fire[p]  = w_out_valid[p] && bus.out_ready[p];
        assign bus.out_valid[p] = w_out_valid[p];
        assign bus.out_flit[p*FLIT_W +: FLIT_W] = w_out_valid[p] ? w_head[r_lock_own[p]]
                                                                 : {FLIT_W{1'b0}};
    end

    // Round-robin grant per unlocked output, searching from last_grant+1.
    always_comb begin
        w_gnt_vld   = 5'b0;
        w_gnt_to_in = 5'b0;
        w_cand      = 0;
        for (int o = 0; o < 5; o++) begin
            w_gnt_idx[o] = 3'd0;
            for (int k = 1; k <= 5; k++) begin
                w_cand = (int'(r_rr[o]) + k) % 5;
                w_gnt_idx[o] = (!w_gnt_vld[o] && (r_state[w_cand] == ST_WAIT)
                                && (r_route[w_cand] == 3'(o))) ? 3'(w_cand) : w_gnt_idx[o];
                w_gnt_vld[o] = w_gnt_vld[o] || ((r_state[w_cand] == ST_WAIT)
                                && (r_route[w_cand] == 3'(o)));
            end
            w_gnt_vld[o] = w_gnt_vld[o] && !r_lock_vld[o];
        end
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                w_gnt_to_in[i] = w_gnt_to_in[i] || (w_gnt_vld[o] && (w_gnt_idx[o] == 3'(i)));
            end
        end
    end

    // FIFO pop selection and error event detection per input state.
    always_comb begin
        w_pop       = 5'b0;
        w_drop_evt  = 1'b0;
        w_proto_evt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (r_state[i])
                ST_IDLE: begin
                    w_pop[i]    = !w_empty[i] && !w_head[i][HEAD_B];
                    w_proto_evt = w_proto_evt || (!w_empty[i] && !w_head[i][HEAD_B]);
                    w_drop_evt  = w_drop_evt || (!w_empty[i] && w_head[i][HEAD_B] && !w_rt_ok[i]);
                end
                ST_FWD:  w_pop[i] = w_out_fire[r_route[i]];
                ST_DROP: w_pop[i] = !w_empty[i];
                default: w_pop[i] = 1'b0;
            endcase
        end
    end

    // Per-input packet state machine and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                r_state[i] <= ST_IDLE;
                r_route[i] <= PORT_L;
            end
            r_err_drop  <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_err_drop  <= w_drop_evt;
            r_err_proto <= w_proto_evt;
            for (int i = 0; i < 5; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (!w_empty[i] && w_head[i][HEAD_B]) begin
                            r_route[i] <= w_rt[i];
                            r_state[i] <= w_rt_ok[i] ? ST_WAIT : ST_DROP;
                        end
                    end
                    ST_WAIT: begin
                        if (w_gnt_to_in[i]) begin
                            r_state[i] <= ST_FWD;
                        end
                    end
                    ST_FWD, ST_DROP: begin
                        if (w_pop[i] && w_head[i][TAIL_B]) begin
                            r_state[i] <= ST_IDLE;
                        end
                    end
                    default: r_state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // Output locks and round-robin pointers; a lock releases as its tail leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_vld <= 5'b0;
            for (int o = 0; o < 5; o++) begin
                r_lock_own[o] <= 3'd0;
                r_rr[o]       <= 3'd4;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (r_lock_vld[o]) begin
                    if (w_out_fire[o] && w_head[r_lock_own[o]][TAIL_B]) begin
                        r_lock_vld[o] <= 1'b0;
                    end
                end else if (w_gnt_vld[o]) begin
                    r_lock_vld[o] <= 1'b1;
                    r_lock_own[o] <= w_gnt_idx[o];
                    r_rr[o]       <= w_gnt_idx[o];
                end
            end
        end
    end
endmodule

// File: tb/tb_mesh_router_wh.sv
// Bench for mesh_router_wh: router A at (1,1) and router B at (3,3) in a 4x4 mesh.
module tb_mesh_router_wh;
    localparam int DW    = 32;
    localparam int FW    = DW + 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mesh_router_wh_if #(.FLIT_W(FW)) ifa ();
    mesh_router_wh_if #(.FLIT_W(FW)) ifb ();

    logic [5*FW-1:0] d_in_flit [2];
    logic [4:0]      d_in_valid [2];
    logic [4:0]      d_out_ready [2];
    logic [4:0]      m_in_ready [2];
    logic [4:0]      m_out_valid [2];
    logic [5*FW-1:0] m_out_flit [2];
    logic            m_err_drop [2];
    logic            m_err_proto [2];

    assign ifa.in_flit = d_in_flit[0];   assign ifb.in_flit = d_in_flit[1];
    assign ifa.in_valid = d_in_valid[0]; assign ifb.in_valid = d_in_valid[1];
    assign ifa.out_ready = d_out_ready[0]; assign ifb.out_ready = d_out_ready[1];
    assign m_in_ready[0] = ifa.in_ready;   assign m_in_ready[1] = ifb.in_ready;
    assign m_out_valid[0] = ifa.out_valid; assign m_out_valid[1] = ifb.out_valid;
    assign m_out_flit[0] = ifa.out_flit;   assign m_out_flit[1] = ifb.out_flit;
    assign m_err_drop[0] = ifa.err_drop;   assign m_err_drop[1] = ifb.err_drop;
    assign m_err_proto[0] = ifa.err_proto; assign m_err_proto[1] = ifb.err_proto;

    mesh_router_wh #(.DATA_WIDTH(DW), .COORD_W(4), .FIFO_DEPTH(DEPTH), .MESH_SIZE_X(4),
                     .MESH_SIZE_Y(4), .X_COORD(1), .Y_COORD(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mesh_router_wh #(.DATA_WIDTH(DW), .COORD_W(4), .FIFO_DEPTH(DEPTH), .MESH_SIZE_X(4),
                     .MESH_SIZE_Y(4), .X_COORD(3), .Y_COORD(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference routing: X first, then Y, local when both match.
    function automatic int model_route(input int cx, input int cy, input int dx, input int dy);
        if (dx == cx && dy == cy) return 4;
        if (cx < dx) return 1;
        if (cx > dx) return 3;
        if (cy < dy) return 2;
        return 0;
    endfunction

    function automatic bit model_present(input int cx, input int cy, input int o);
        case (o)
            0:       return cy != 0;
            1:       return cx != 3;
            2:       return cy != 3;
            3:       return cx != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [FW-1:0] mk_head(input int dx, input int dy, input bit tail);
        logic [31:0] pay;
        logic [3:0]  ex, ey;
        pay = $urandom;
        ex = 4'(dx);
        ey = 4'(dy);
        pay[31:24] = {ex, ey};
        return {1'b1, tail, pay};
    endfunction

    // One packet from (sel, src); outputs checked against the model every cycle.
    task automatic pkt(input int sel, input int src, input int dx, input int dy, input int len,
                       input int stall, input bit rnd_ready, output int k_first, output int k_last);
        logic [FW-1:0] fl[$];
        logic [FW-1:0] lane;
        logic [4:0]    mask;
        int cx, cy, o, sent, got, k, drops, protos, done_k;
        bit drop;
        cx = (sel == 1) ? 3 : 1;
        cy = cx;
        sent = 0; got = 0; k = 0; drops = 0; protos = 0; done_k = -1;
        k_first = -1; k_last = -1;
        for (int i = 0; i < len; i++) begin
            if (i == 0) fl.push_back(mk_head(dx, dy, len == 1));
            else        fl.push_back({1'b0, (i == len - 1), 32'($urandom)});
        end
        o = model_route(cx, cy, dx, dy);
        drop = !model_present(cx, cy, o);
        mask = drop ? 5'h1f : ~(5'b00001 << o);
        forever begin
            if (sent < len) begin
                d_in_flit[sel][src*FW +: FW] = fl[sent];
                d_in_valid[sel][src] = 1'b1;
            end else begin
                d_in_valid[sel][src] = 1'b0;
            end
            d_out_ready[sel] = rnd_ready ? 5'($urandom) : 5'h1f;
            if (k < stall) d_out_ready[sel][o] = 1'b0;
            #1;
            chk("stray_valid", 64'(m_out_valid[sel] & mask), 64'd0);
            lane = m_out_flit[sel][o*FW +: FW];
            if (!drop) begin
                if (m_out_valid[sel][o]) begin
                    if (d_out_ready[sel][o]) begin
                        if (got < len) chk("flit", 64'(lane), 64'(fl[got]));
                        else           chk("extra_flit", 64'(got), 64'(len - 1));
                        if (k_first < 0) k_first = k;
                        k_last = k;
                        got++;
                    end
                end else begin
                    chk("idle_lane_zero", 64'(lane), 64'd0);
                end
                if (stall >= 8 && k == stall - 1) begin
                    chk("stall_fill", 64'(sent), 64'(DEPTH));
                    chk("stall_in_ready", 64'(m_in_ready[sel][src]), 64'd0);
                    chk("stall_valid", 64'(m_out_valid[sel][o]), 64'd1);
                    chk("stall_hold", 64'(lane), 64'(fl[0]));
                end
            end
            if (d_in_valid[sel][src] && m_in_ready[sel][src]) sent++;
            drops += int'(m_err_drop[sel]);
            protos += int'(m_err_proto[sel]);
            if (sent == len && done_k < 0) done_k = k;
            k++;
            @(negedge clk);
            if (drop ? (done_k >= 0 && k > done_k + len + 4) : (got == len)) break;
            if (k > 400) begin
                chk("timeout", 64'(got), 64'(len));
                break;
            end
        end
        d_in_valid[sel] = 5'b0;
        d_out_ready[sel] = 5'h1f;
        chk("err_drop_count", 64'(drops), drop ? 64'd1 : 64'd0);
        chk("err_proto_count", 64'(protos), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Two 2-flit packets to L of router A presented on the same edge.
    task automatic contest(input int sa, input int sb, input int first, input bit timing);
        logic [FW-1:0] pk [5][2];
        logic [FW-1:0] ex [4];
        int kexp [4];
        int got, k, second;
        second = (first == sa) ? sb : sa;
        for (int s = 0; s < 5; s++) begin
            pk[s][0] = mk_head(1, 1, 1'b0);
            pk[s][1] = {1'b0, 1'b1, 32'($urandom)};
        end
        ex[0] = pk[first][0];  ex[1] = pk[first][1];
        ex[2] = pk[second][0]; ex[3] = pk[second][1];
        kexp[0] = 3; kexp[1] = 4; kexp[2] = 6; kexp[3] = 7;
        got = 0;
        k = 0;
        forever begin
            if (k < 2) begin
                d_in_flit[0][sa*FW +: FW] = pk[sa][k];
                d_in_flit[0][sb*FW +: FW] = pk[sb][k];
                d_in_valid[0][sa] = 1'b1;
                d_in_valid[0][sb] = 1'b1;
            end else begin
                d_in_valid[0] = 5'b0;
            end
            #1;
            if (m_out_valid[0][4]) begin
                if (got < 4) chk("contest_flit", 64'(m_out_flit[0][4*FW +: FW]), 64'(ex[got]));
                if (timing && got < 4) chk("contest_cycle", 64'(k), 64'(kexp[got]));
                got++;
            end
            k++;
            @(negedge clk);
            if (got >= 4) break;
            if (k > 60) begin
                chk("contest_timeout", 64'(got), 64'd4);
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kf, kl, cnt, sel, src, dx, dy, len;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            d_in_flit[s] = '0;
            d_in_valid[s] = 5'b0;
            d_out_ready[s] = 5'h1f;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", 64'(m_in_ready[s]), 64'd0);
            chk("rst_out_valid", 64'(m_out_valid[s]), 64'd0);
            chk("rst_out_flit", 64'(m_out_flit[s] == '0), 64'd1);
            chk("rst_errs", 64'({m_err_drop[s], m_err_proto[s]}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready_a", 64'(m_in_ready[0]), 64'h1f);
        chk("post_rst_in_ready_b", 64'(m_in_ready[1]), 64'h1f);

        // W to (3,1): leaves on E with first flit 3 cycles after the head is written.
        pkt(0, 3, 3, 1, 3, 0, 1'b0, kf, kl);
        chk("lat_first", 64'(kf), 64'd3);
        chk("lat_last", 64'(kl), 64'd5);
        // Single-flit packets take and release the E lock in one transfer.
        pkt(0, 4, 2, 1, 1, 0, 1'b0, kf, kl);
        chk("single_lat", 64'(kf), 64'd3);
        pkt(0, 4, 3, 2, 1, 0, 1'b0, kf, kl);
        chk("single_relock", 64'(kf), 64'd3);

        // L pointer starts at 4: N wins, S follows after one bubble.
        contest(0, 2, 0, 1'b1);
        // Last grant was S, so search resumes at W.
        contest(3, 1, 3, 1'b0);
        // Last grant was E, so search resumes at S.
        contest(1, 2, 2, 1'b0);

        // Backpressure: FIFO fills with 4 flits then in_ready drops; all 8 delivered in order.
        pkt(0, 3, 3, 1, 8, 10, 1'b0, kf, kl);

        // Orphan body flit on E while IDLE: one err_proto pulse, no output.
        d_in_flit[0][1*FW +: FW] = {1'b0, 1'b1, 32'hDEAD_BEEF};
        d_in_valid[0][1] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k == 1) d_in_valid[0][1] = 1'b0;
            chk("proto_no_out", 64'(m_out_valid[0]), 64'd0);
            cnt += int'(m_err_proto[0]);
            @(negedge clk);
            d_in_valid[0][1] = 1'b0;
        end
        chk("proto_pulses", 64'(cnt), 64'd1);
        pkt(0, 1, 1, 1, 2, 0, 1'b0, kf, kl);

        // Reset mid-packet: nothing emitted afterwards, fresh packet routes normally.
        for (int k = 0; k < 4; k++) begin
            d_in_flit[0][3*FW +: FW] = (k == 0) ? mk_head(3, 1, 1'b0) : {2'b00, 32'($urandom)};
            d_in_valid[0][3] = (k < 3);
            @(negedge clk);
        end
        #1;
        chk("mid_pkt_valid", 64'(m_out_valid[0][1]), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(m_out_valid[0]), 64'd0);
        chk("rst_mid_ready", 64'(m_in_ready[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("after_rst_valid", 64'(m_out_valid[0]), 64'd0);
            chk("after_rst_ready", 64'(m_in_ready[0]), 64'h1f);
            @(negedge clk);
        end
        pkt(0, 3, 3, 1, 3, 0, 1'b0, kf, kl);
        chk("after_rst_lat", 64'(kf), 64'd3);

        // Router B at (3,3): local delivery, drops toward absent S and E.
        pkt(1, 4, 3, 3, 2, 0, 1'b0, kf, kl);
        pkt(1, 4, 3, 9, 3, 0, 1'b0, kf, kl);
        pkt(1, 4, 9, 3, 2, 0, 1'b0, kf, kl);
        pkt(1, 4, 3, 3, 3, 0, 1'b0, kf, kl);

        // Randomized packets with random backpressure.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 1);
            src = $urandom_range(0, 4);
            dx  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            dy  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            pkt(sel, src, dx, dy, len, 0, 1'b1, kf, kl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
